mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Shares one sequential 8×8 signed Booth multiplier between `N_REQ` requesters. Requesters post operand pairs, and the block grants them in round-robin order. For the granted requester it drives the multiplier's start/operand inputs, waits for `Done`, and returns the 16-bit product with a one-cycle acknowledge. It sits between the multiplier instance and the client logic, and is the only driver of the multiplier's `St`, `Mplier` and `Mcand`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 31: maximum number of WAIT cycles before the block aborts with an error. Must be ≥ 20.
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level. The requester holds it until its `ack`.
- `mplier_in`  in  8·N_REQ  signed multiplier operand; slice i belongs to requester i.
- `mcand_in`  in  8·N_REQ  signed multiplicand operand; slice i belongs to requester i.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: the result for requester i is valid.
- `product`  out  16  signed result. Valid only while `ack` is non-zero.
- `err`  out  1  qualifies `ack`: the operation timed out and `product` = 0.
- `busy`  out  1  high in every state except IDLE.
- `gnt_id`  out  3  index of the current or last granted requester.
- `mul_st`  out  1  to multiplier `St`.
- `mul_mplier`  out  8  to multiplier `Mplier`.
- `mul_mcand`  out  8  to multiplier `Mcand`.
- `mul_product`  in  16  from multiplier `Product`.
- `mul_done`  in  1  from multiplier `Done`. The level stays high until the multiplier accepts the next start.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `mul_st` = 1 for exactly this one cycle.
  - WAIT: poll `mul_done` and count timeout.
  - RESP: drive `ack`.
- Arbitration in IDLE:
  - If any `req` bit is set, the block picks the first set bit at or after `last+1` (mod N_REQ).
  - It latches that requester's operands into `mul_mplier`/`mul_mcand`, sets `gnt_id`, updates `last`, and moves to ISSUE.
  - With no request it stays in IDLE.
- ISSUE → WAIT unconditionally. The timeout counter is cleared here.
- WAIT:
  - `mul_done` is never sampled in ISSUE, because it may still be high from the previous operation. The multiplier clears it on the ISSUE edge.
  - When `mul_done` = 1: latch `mul_product` and go to RESP with `err` = 0.
  - When the counter reaches `TIMEOUT` first: `product` = 0 and go to RESP with `err` = 1.
  - If the timeout and `mul_done` both occur in the same cycle, `mul_done` wins.
- RESP:
  - `ack[gnt_id]` = 1 for one cycle, then IDLE.
  - `product`, `err` and `gnt_id` hold their values until the next RESP.
- The requester must drop `req` on the edge that ends its `ack` cycle. `req` is sampled only in IDLE, so a drop after grant is ignored and the result is still delivered.
- `mul_mplier`/`mul_mcand` stay constant from ISSUE through RESP.
- Reset values:
  - State = IDLE; `ack` = 0; `product` = 0; `err` = 0; `busy` = 0; `gnt_id` = 0; `mul_st` = 0; `mul_mplier`/`mul_mcand` = 0.
  - `last` = N_REQ−1, so requester 0 has first priority.
- Reset mid-operation returns everything to the reset values immediately. The multiplier has no reset, so a start issued while it is still busy may be ignored; the timeout then recovers with `err` = 1.

## Timing
- `req` high in IDLE at cycle t gives ISSUE at t+1 and WAIT from t+2.
- The multiplier needs 8–16 cycles after its start edge.
- RESP is the cycle after the first WAIT cycle that sees `mul_done` = 1. End-to-end latency is 11–19 cycles.
- Back-to-back operations: IDLE follows RESP with no bubble, so there is one arbitration per operation.
- A timeout gives `ack` exactly at t+2+TIMEOUT+1.
- All outputs are registered. `busy` is decoded from the state register.

## Structure
- Package `mult_arb_pkg` holds:
  - the state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits);
  - the operand width 8 and product width 16;
  - the `gnt_id` width 3;
  - the timeout counter width 6.
- Sub-module `rr_pick`: a combinational round-robin picker. It takes `req` and `last`, and returns `valid` and the granted index. It is instantiated once.
- The testbench instantiates the real multiplier behind the block.

## Test plan
- Single request: `req[0]`, operands 7×(−3) → `ack[0]` with `product` = 16'hFFEB (−21), `err` = 0, latency within 11–19 cycles.
- Extremes on requester 2: (−128)×(−128) → `product` = 16'h4000; 127×(−128) → 16'hC080.
- All four `req` held continuously, each with distinct operands → acks in order 0,1,2,3,0. Each product is correct, and there is never more than one `ack` bit per cycle.
- `req[1]` dropped during WAIT → `ack[1]` still pulses with the correct product. No further grant to requester 1 follows.
- Multiplier model with `mul_done` stuck at 0 → `ack` with `err` = 1 and `product` = 0 at exactly TIMEOUT+3 cycles after grant; `busy` returns to 0.
- `Rst_n` asserted during WAIT → all outputs return to their reset values asynchronously. The next request after release is served correctly, or flagged with `err` = 1, and never hangs.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared widths and FSM encoding for the shared-multiplier arbiter.
package mult_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int GNT_W  = 3;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Client-side and multiplier-side signals of the arbiter, bundled for port lists.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]      req;
  logic [OP_W*N_REQ-1:0] mplier_in;
  logic [OP_W*N_REQ-1:0] mcand_in;
  logic [N_REQ-1:0]      ack;
  logic [PROD_W-1:0]     product;
  logic                  err;
  logic                  busy;
  logic [GNT_W-1:0]      gnt_id;
  logic                  mul_st;
  logic [OP_W-1:0]       mul_mplier;
  logic [OP_W-1:0]       mul_mcand;
  logic [PROD_W-1:0]     mul_product;
  logic                  mul_done;

  // The arbiter itself is the slave; requesters plus multiplier form the master side.
  modport slave (
    input  req, mplier_in, mcand_in, mul_product, mul_done,
    output ack, product, err, busy, gnt_id, mul_st, mul_mplier, mul_mcand
  );

  modport master (
    output req, mplier_in, mcand_in, mul_product, mul_done,
    input  ack, product, err, busy, gnt_id, mul_st, mul_mplier, mul_mcand
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] last,
  output logic             valid,
  output logic [GNT_W-1:0] idx
);

  logic [N_REQ-1:0] upper;

  for (genvar g = 0; g < N_REQ; g++) begin : g_mask
    assign upper[g] = req[g] & (GNT_W'(g) > last);
  end

  // Requests above 'last' win; with none there, wrap to the lowest set bit.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (upper != '0) begin
        if (upper[i]) idx = GNT_W'(i);
      end else if (req[i]) begin
        idx = GNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one sequential signed multiplier among N_REQ requesters in round-robin order.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 31
) (
  input logic                 Clk,
  input logic                 Rst_n,
  mult_share_arbiter_if.slave bus
);

  state_t            state;
  logic [GNT_W-1:0]  last;
  logic [GNT_W-1:0]  gnt;
  logic [GNT_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt;
  logic [N_REQ-1:0]  ack_r;
  logic [N_REQ-1:0]  gnt_onehot;
  logic [PROD_W-1:0] product_r;
  logic              err_r;
  logic              st_r;
  logic [OP_W-1:0]   mplier_r;
  logic [OP_W-1:0]   mcand_r;
  logic [OP_W-1:0]   sel_mplier;
  logic [OP_W-1:0]   sel_mcand;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_mplier = '0;
    sel_mcand  = '0;
    gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GNT_W'(i)) begin
        sel_mplier = bus.mplier_in[i*OP_W +: OP_W];
        sel_mcand  = bus.mcand_in[i*OP_W +: OP_W];
      end
      gnt_onehot[i] = (gnt == GNT_W'(i));
    end
  end

  // mul_done is ignored in ISSUE: it may still be high from the previous product.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      last      <= GNT_W'(N_REQ - 1);
      gnt       <= '0;
      cnt       <= '0;
      ack_r     <= '0;
      product_r <= '0;
      err_r     <= 1'b0;
      st_r      <= 1'b0;
      mplier_r  <= '0;
      mcand_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mplier_r <= sel_mplier;
            mcand_r  <= sel_mcand;
            gnt      <= pick_idx;
            last     <= pick_idx;
            st_r     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          st_r  <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            product_r <= bus.mul_product;
            err_r     <= 1'b0;
            ack_r     <= gnt_onehot;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            product_r <= '0;
            err_r     <= 1'b1;
            ack_r     <= gnt_onehot;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ack_r <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_r;
  assign bus.product    = product_r;
  assign bus.err        = err_r;
  assign bus.busy       = (state != IDLE);
  assign bus.gnt_id     = gnt;
  assign bus.mul_st     = st_r;
  assign bus.mul_mplier = mplier_r;
  assign bus.mul_mcand  = mcand_r;

endmodule
